mem_access_arbiter: RTL and testbench
=====================================

# mem_access_arbiter

Two-requester arbiter and sequencer for the 27-bit line memory (M_Memory class). It shares the memory between the DDT capture path (writer) and the RGB output path (reader). It drives the memory's active-low enable / read-write select with registered outputs and inserts a turnaround bubble on every direction change. It returns read data with a fixed, parameterised latency.

## Interface
- READ_LATENCY, 2: memory clocks from an issued read to valid Mem_Dbus_out.
- MAX_BURST, 8: maximum consecutive same-direction grants before forced re-arbitration (fairness build only).
- Sys_Clock  in  1  single clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Wr_Req  in  1  write request; holds Wr_Addr/Wr_Data stable until Wr_Gnt.
- Wr_Addr  in  21  write address.
- Wr_Data  in  27  write data.
- Wr_Gnt  out  1  one-cycle pulse; write accepted this cycle.
- Rd_Req  in  1  read request; holds Rd_Addr stable until Rd_Gnt.
- Rd_Addr  in  21  read address.
- Rd_Gnt  out  1  one-cycle pulse; read accepted this cycle.
- Rd_Valid  out  1  one-cycle pulse; Rd_Data valid.
- Rd_Data  out  27  returned read data.
- Mem_EN  out  1  memory enable, active low.
- Mem_WE  out  1  1 = read, 0 = write; meaningful only when Mem_EN = 0.
- Mem_Addr  out  21  memory address.
- Mem_Dbus_in  out  27  memory write data.
- Mem_Dbus_out  in  27  memory read data.

## Operation
- Reset values: Wr_Gnt = 0, Rd_Gnt = 0, Rd_Valid = 0, Rd_Data = 0, Mem_EN = 1, Mem_WE = 1, Mem_Addr = 0, Mem_Dbus_in = 0. State is IDLE, burst counter is 0, last direction is WRITE, and the read-valid pipe is cleared.
- States: IDLE, WRITE, READ, TURN.
- IDLE:
  - Selects a direction from pending requests and moves to WRITE or READ.
  - No request: stays in IDLE with Mem_EN = 1.
- WRITE / READ:
  - Each cycle with the matching request asserted, grants it, issues one access and increments the burst counter.
  - Matching request low: goes to IDLE if the other request is also low, otherwise to TURN.
- Leaving a direction while the other request is pending always passes through TURN.
  - TURN lasts 1 cycle with Mem_EN = 1.
  - TURN then enters the opposite direction.
- Burst counter clears on entry to WRITE or READ.
- Direction selection when both requests are pending: see Configuration.
- Read return: a READ_LATENCY+1 deep shift register of valid bits tracks issued reads. When a bit exits, Mem_Dbus_out is captured into Rd_Data and Rd_Valid pulses.
- Reads are never reordered; one Rd_Valid is produced per Rd_Gnt.
- Writes have no completion signal.
- Addresses and data pass through unmodified; there is no width conversion.

## Timing
- Gnt is combinational from state and request in cycle N.
- Mem_EN, Mem_WE, Mem_Addr and Mem_Dbus_in are registered and present the access in cycle N+1.
- Rd_Valid / Rd_Data are registered and appear in cycle N+1+READ_LATENCY. Default: 3 cycles after Rd_Gnt.
- Throughput: one access per cycle within a direction. A direction change costs exactly 1 bubble cycle.
- A request dropped without a grant is legal; no access is issued for it.
- Reset mid-operation: in-flight reads are discarded with no Rd_Valid. Mem_EN returns to 1 on the cycle after Reset is sampled.

## Configuration
- MEM_ARB_FAIRNESS_EN defined:
  - Round-robin. When both requests are pending in IDLE, the direction opposite to last direction wins.
  - In WRITE or READ, when the burst counter reaches MAX_BURST and the other request is pending, the block goes to TURN.
- MEM_ARB_FAIRNESS_EN undefined:
  - Fixed read priority. When both are pending in IDLE, READ wins.
  - In WRITE, a pending Rd_Req forces TURN after the current grant.
  - READ runs until Rd_Req drops.
  - MAX_BURST is unused and the burst counter is not built.

## Structure
- Shared package: state enum (IDLE, WRITE, READ, TURN), MEM_ADDR_W = 21, MEM_DATA_W = 27, and memory encodings (MEM_EN_ACTIVE = 0, MEM_WE_READ = 1, MEM_WE_WRITE = 0).
- One sub-module: mem_rd_return_pipe. It holds the READ_LATENCY-deep valid shift register and the Rd_Data capture register.

## Test plan
- Reset, no requests for 10 cycles: Mem_EN stays 1 and all Gnt/Valid stay 0.
- Rd_Req with Rd_Addr = 0x00005 for 1 grant, Mem_Dbus_out = 0x1234567 at the return cycle: Rd_Gnt at N; Mem_EN = 0, Mem_WE = 1, Mem_Addr = 5 at N+1; Rd_Valid with Rd_Data = 0x1234567 at N+3.
- Write burst to addresses 0..3, then an immediate read: 4 consecutive Wr_Gnt, 1 TURN cycle with Mem_EN = 1, then Rd_Gnt.
- Both requests held, fairness build, MAX_BURST = 8: READ wins first; after 8 reads, 1 TURN; then 8 writes; alternation repeats.
- Both requests held, fairness build excluded: reads granted every cycle and Wr_Gnt never asserts until Rd_Req drops.
- Reset asserted 1 cycle after Rd_Gnt: no Rd_Valid ever appears for that read, and outputs match reset values on the next cycle.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the line-memory arbiter.
// Holds the FSM state encoding, the access direction type, the memory
// bus widths and the active-low enable / read-write select encodings.
package mem_access_arbiter_pkg;

    localparam int MEM_ADDR_W = 21;
    localparam int MEM_DATA_W = 27;

    localparam logic MEM_EN_ACTIVE = 1'b0;
    localparam logic MEM_EN_IDLE   = 1'b1;
    localparam logic MEM_WE_READ   = 1'b1;
    localparam logic MEM_WE_WRITE  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_e;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } arb_dir_e;

    // State that serves the direction opposite to the one given.
    function automatic arb_state_e opposite_state(input arb_dir_e dir);
        return (dir == DIR_WRITE) ? ST_READ : ST_WRITE;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rd_return_pipe.sv
// Read-return pipeline for the line-memory arbiter (module mem_rd_return_pipe).
// A READ_LATENCY-deep valid shift register follows each issued read; when a
// bit leaves the last stage the memory read bus is captured into the output
// data register and the valid pulse is raised in the same registered cycle.
module mem_rd_return_pipe
    import mem_access_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_i,
    input  logic [MEM_DATA_W-1:0] mem_data_i,
    output logic                  rd_valid_o,
    output logic [MEM_DATA_W-1:0] rd_data_o
);

    logic [READ_LATENCY-1:0] valid_q;
    logic                    rd_valid_q;
    logic [MEM_DATA_W-1:0]   rd_data_q;

    // Shift issued-read markers; a reset drops every read still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= issue_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Capture returning memory data as its marker leaves the pipe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= valid_q[READ_LATENCY-1];
            if (valid_q[READ_LATENCY-1]) begin
                rd_data_q <= mem_data_i;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// Writer/reader arbiter and sequencer for the 27-bit line memory.
// Grants are combinational; the memory strobes, address and write data are
// registered one cycle after the grant. Every direction change passes
// through a one-cycle TURN bubble with the memory disabled.
// Build option MEM_ARB_FAIRNESS_EN: round-robin selection with bursts capped
// at MAX_BURST; without it reads have fixed priority and no burst counter exists.
//
// state | meaning
// IDLE  | no access in progress; picks a direction from pending requests
// WRITE | one write granted per cycle while Wr_Req is held
// READ  | one read granted per cycle while Rd_Req is held
// TURN  | one-cycle bus turnaround, then the opposite direction
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8
) (
    input  logic                  Sys_Clock,
    input  logic                  Reset,
    input  logic                  Wr_Req,
    input  logic [MEM_ADDR_W-1:0] Wr_Addr,
    input  logic [MEM_DATA_W-1:0] Wr_Data,
    output logic                  Wr_Gnt,
    input  logic                  Rd_Req,
    input  logic [MEM_ADDR_W-1:0] Rd_Addr,
    output logic                  Rd_Gnt,
    output logic                  Rd_Valid,
    output logic [MEM_DATA_W-1:0] Rd_Data,
    output logic                  Mem_EN,
    output logic                  Mem_WE,
    output logic [MEM_ADDR_W-1:0] Mem_Addr,
    output logic [MEM_DATA_W-1:0] Mem_Dbus_in,
    input  logic [MEM_DATA_W-1:0] Mem_Dbus_out
);

    if (READ_LATENCY < 1 || MAX_BURST < 1) begin : g_bad_params
        $error("mem_access_arbiter: READ_LATENCY and MAX_BURST must both be at least 1");
    end

    arb_state_e state_q, state_d;
    arb_dir_e   last_dir_q, last_dir_d;

    logic wr_gnt, rd_gnt;

    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;
    logic [MEM_DATA_W-1:0] mem_dbus_q;

    // Choice when both requests are pending in IDLE, and whether the active
    // direction must hand over after the current grant when the other waits.
    arb_state_e both_pick;
    logic       wr_yield;
    logic       rd_yield;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    logic [BURST_W-1:0] burst_q, burst_d;
    logic               burst_last;

    // The grant in flight is the MAX_BURST-th of this run (or later).
    assign burst_last = (burst_q >= (BURST_MAX - 1'b1));
    assign both_pick  = opposite_state(last_dir_q);
    assign wr_yield   = burst_last;
    assign rd_yield   = burst_last;

    // Count grants within a run; restart on entering a direction, saturate at the cap.
    always_comb begin
        burst_d = burst_q;
        if ((state_d == ST_WRITE || state_d == ST_READ) && (state_d != state_q)) begin
            burst_d = '0;
        end else if ((wr_gnt || rd_gnt) && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    // Burst counter register.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign both_pick = ST_READ;
    assign wr_yield  = 1'b1;
    assign rd_yield  = 1'b0;
`endif

    // State and last-direction registers.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_WRITE;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        case (state_q)
            ST_IDLE: begin
                if (Wr_Req && Rd_Req) begin
                    state_d = both_pick;
                end else if (Rd_Req) begin
                    state_d = ST_READ;
                end else if (Wr_Req) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!Wr_Req) begin
                    state_d = Rd_Req ? ST_TURN : ST_IDLE;
                end else if (Rd_Req && wr_yield) begin
                    state_d = ST_TURN;
                end
            end
            ST_READ: begin
                if (!Rd_Req) begin
                    state_d = Wr_Req ? ST_TURN : ST_IDLE;
                end else if (Wr_Req && rd_yield) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = opposite_state(last_dir_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_WRITE) begin
            last_dir_d = DIR_WRITE;
        end else if (state_d == ST_READ) begin
            last_dir_d = DIR_READ;
        end
    end

    // Grants; suppressed during reset because the access would be dropped.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (!Reset) begin
            wr_gnt = (state_q == ST_WRITE) && Wr_Req;
            rd_gnt = (state_q == ST_READ)  && Rd_Req;
        end
    end

    // Register the granted access onto the memory bus one cycle later.
    always_ff @(posedge Sys_Clock) begin
        if (Reset) begin
            mem_en_q   <= MEM_EN_IDLE;
            mem_we_q   <= MEM_WE_READ;
            mem_addr_q <= '0;
            mem_dbus_q <= '0;
        end else begin
            mem_en_q <= (wr_gnt || rd_gnt) ? MEM_EN_ACTIVE : MEM_EN_IDLE;
            mem_we_q <= wr_gnt ? MEM_WE_WRITE : MEM_WE_READ;
            if (wr_gnt) begin
                mem_addr_q <= Wr_Addr;
                mem_dbus_q <= Wr_Data;
            end else if (rd_gnt) begin
                mem_addr_q <= Rd_Addr;
            end
        end
    end

    mem_rd_return_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rd_return_pipe (
        .clk_i     (Sys_Clock),
        .rst_i     (Reset),
        .issue_i   (rd_gnt),
        .mem_data_i(Mem_Dbus_out),
        .rd_valid_o(Rd_Valid),
        .rd_data_o (Rd_Data)
    );

    assign Wr_Gnt      = wr_gnt;
    assign Rd_Gnt      = rd_gnt;
    assign Mem_EN      = mem_en_q;
    assign Mem_WE      = mem_we_q;
    assign Mem_Addr    = mem_addr_q;
    assign Mem_Dbus_in = mem_dbus_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a read-data scoreboard and a
// per-cycle memory-bus checker. A small memory model returns data derived
// from the read address one cycle after the registered read access.
module tb_mem_access_arbiter;

    logic        clk;
    logic        Reset;
    logic        Wr_Req;
    logic [20:0] Wr_Addr;
    logic [26:0] Wr_Data;
    logic        Wr_Gnt;
    logic        Rd_Req;
    logic [20:0] Rd_Addr;
    logic        Rd_Gnt;
    logic        Rd_Valid;
    logic [26:0] Rd_Data;
    logic        Mem_EN;
    logic        Mem_WE;
    logic [20:0] Mem_Addr;
    logic [26:0] Mem_Dbus_in;
    logic [26:0] Mem_Dbus_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [26:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    mem_access_arbiter dut (
        .Sys_Clock   (clk),
        .Reset       (Reset),
        .Wr_Req      (Wr_Req),
        .Wr_Addr     (Wr_Addr),
        .Wr_Data     (Wr_Data),
        .Wr_Gnt      (Wr_Gnt),
        .Rd_Req      (Rd_Req),
        .Rd_Addr     (Rd_Addr),
        .Rd_Gnt      (Rd_Gnt),
        .Rd_Valid    (Rd_Valid),
        .Rd_Data     (Rd_Data),
        .Mem_EN      (Mem_EN),
        .Mem_WE      (Mem_WE),
        .Mem_Addr    (Mem_Addr),
        .Mem_Dbus_in (Mem_Dbus_in),
        .Mem_Dbus_out(Mem_Dbus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [26:0] rd_model(input logic [20:0] a);
        return 27'h1234562 + {6'd0, a};
    endfunction

    function automatic logic [26:0] wr_model(input int i);
        return 27'h5A5A000 + 27'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input bit rd, output int waited);
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((rd ? Rd_Gnt : Wr_Gnt) === 1'b1) return;
            waited++;
        end
        checks++;
        errors++;
        $error("FAIL gnt_timeout: observed no grant after %0d cycles expected grant (rd=%0d)", waited, rd);
    endtask

    // Memory model: a read seen on the bus in cycle c returns data in cycle c+1.
    logic        m_rd;
    logic [20:0] m_addr;
    initial begin
        Mem_Dbus_out = '0;
        forever begin
            @(negedge clk);
            m_rd   = (Mem_EN === 1'b0) && (Mem_WE === 1'b1);
            m_addr = Mem_Addr;
            @(posedge clk);
            #1 Mem_Dbus_out = m_rd ? rd_model(m_addr) : 27'h0;
        end
    end

    // Bus and read-return checker, one pass per cycle.
    logic        pv_reset = 1'b1;
    logic        pv_wg    = 1'b0;
    logic        pv_rg    = 1'b0;
    logic [20:0] pv_waddr, pv_raddr;
    logic [26:0] pv_wdata;
    logic        exp_v;
    rd_exp_t     e;
    always @(negedge clk) begin
        exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        check("rd_valid_timing", Rd_Valid, exp_v);
        if (exp_v) begin
            e = sb_q.pop_front();
            check("rd_data", Rd_Data, e.data);
        end
        if (pv_reset) begin
            check("rst_mem_en", Mem_EN, 1'b1);
            check("rst_mem_we", Mem_WE, 1'b1);
            check("rst_mem_addr", Mem_Addr, 0);
            check("rst_mem_dbus", Mem_Dbus_in, 0);
        end else if (pv_wg) begin
            check("wr_mem_en", Mem_EN, 1'b0);
            check("wr_mem_we", Mem_WE, 1'b0);
            check("wr_mem_addr", Mem_Addr, pv_waddr);
            check("wr_mem_dbus", Mem_Dbus_in, pv_wdata);
        end else if (pv_rg) begin
            check("rd_mem_en", Mem_EN, 1'b0);
            check("rd_mem_we", Mem_WE, 1'b1);
            check("rd_mem_addr", Mem_Addr, pv_raddr);
        end else begin
            check("idle_mem_en", Mem_EN, 1'b1);
        end
        check("gnt_exclusive", Wr_Gnt & Rd_Gnt, 1'b0);
        pv_reset = Reset;
        pv_wg    = Wr_Gnt;
        pv_rg    = Rd_Gnt;
        pv_waddr = Wr_Addr;
        pv_wdata = Wr_Data;
        pv_raddr = Rd_Addr;
        if (Reset) begin
            sb_q.delete();
        end else if (Rd_Gnt) begin
            sb_q.push_back('{data: rd_model(Rd_Addr), due: cyc + 3});
        end
    end

    int waited;
    int n_gnt;
    int exp_rd, exp_wr, p;

    initial begin
        Reset   = 1'b1;
        Wr_Req  = 1'b0;
        Wr_Addr = '0;
        Wr_Data = '0;
        Rd_Req  = 1'b0;
        Rd_Addr = '0;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;

        // Quiet after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("quiet_mem_en", Mem_EN, 1'b1);
            check("quiet_wr_gnt", Wr_Gnt, 1'b0);
            check("quiet_rd_gnt", Rd_Gnt, 1'b0);
            check("quiet_rd_valid", Rd_Valid, 1'b0);
            check("quiet_rd_data", Rd_Data, 0);
        end

        // Single read of address 5.
        @(posedge clk);
        #1 Rd_Req = 1'b1; Rd_Addr = 21'h00005;
        wait_gnt(1'b1, waited);
        check("single_rd_gnt_wait", waited, 1);
        @(posedge clk);
        #1 Rd_Req = 1'b0;
        @(negedge clk);
        check("single_rd_en", Mem_EN, 1'b0);
        check("single_rd_we", Mem_WE, 1'b1);
        check("single_rd_addr", Mem_Addr, 21'h5);
        @(negedge clk);
        check("single_rd_valid_early", Rd_Valid, 1'b0);
        @(negedge clk);
        check("single_rd_valid", Rd_Valid, 1'b1);
        check("single_rd_data", Rd_Data, 27'h1234567);

        // Write burst 0..3 followed by a read.
        repeat (2) @(posedge clk);
        #1 Wr_Req = 1'b1; Wr_Addr = 21'd0; Wr_Data = wr_model(0);
        wait_gnt(1'b0, waited);
        check("wr_first_gnt_wait", waited, 1);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1 Wr_Addr = 21'(i); Wr_Data = wr_model(i);
            if (i == 3) begin
                Rd_Req  = 1'b1;
                Rd_Addr = 21'h00100;
            end
            @(negedge clk);
            check("wr_burst_gnt", Wr_Gnt, 1'b1);
        end
        @(posedge clk);
        #1 Wr_Req = 1'b0;
        wait_gnt(1'b1, waited);
`ifdef MEM_ARB_FAIRNESS_EN
        check("turn_bubble_cycles", waited, 2);
`else
        check("turn_bubble_cycles", waited, 1);
`endif
        @(posedge clk);
        #1 Rd_Req = 1'b0;
        repeat (4) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;

        // Both requests held from IDLE.
        Wr_Req  = 1'b1; Rd_Req  = 1'b1;
        Rd_Addr = 21'h200; Wr_Addr = 21'h300; Wr_Data = wr_model(100);
        n_gnt = 0;
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_FAIRNESS_EN
            p      = (k - 1) % 18;
            exp_rd = (k >= 1) && (p < 8);
            exp_wr = (k >= 1) && (p >= 9) && (p < 17);
`else
            exp_rd = (k >= 1);
            exp_wr = 0;
`endif
            check("both_rd_gnt", Rd_Gnt, exp_rd);
            check("both_wr_gnt", Wr_Gnt, exp_wr);
            @(posedge clk);
            #1;
            if (exp_rd != 0) Rd_Addr = 21'h200 + 21'(k);
            if (exp_wr != 0) begin
                Wr_Addr = 21'h300 + 21'(k);
                Wr_Data = wr_model(100 + k);
            end
        end
`ifndef MEM_ARB_FAIRNESS_EN
        Rd_Req = 1'b0;
        wait_gnt(1'b0, waited);
        check("rd_drop_to_wr_wait", waited, 2);
        @(posedge clk);
        #1;
`endif
        Rd_Req = 1'b0;
        Wr_Req = 1'b0;
        repeat (6) @(posedge clk);

        // Reset one cycle after a read grant.
        #1 Rd_Req = 1'b1; Rd_Addr = 21'h00009;
        wait_gnt(1'b1, waited);
        @(posedge clk);
        #1 Rd_Req = 1'b0; Reset = 1'b1;
        @(negedge clk);
        check("rst_inflight_en", Mem_EN, 1'b0);
        @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check("post_rst_en", Mem_EN, 1'b1);
        check("post_rst_we", Mem_WE, 1'b1);
        check("post_rst_addr", Mem_Addr, 0);
        check("post_rst_dbus", Mem_Dbus_in, 0);
        check("post_rst_rd_data", Rd_Data, 0);
        check("post_rst_rd_gnt", Rd_Gnt, 1'b0);
        check("post_rst_wr_gnt", Wr_Gnt, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", Rd_Valid, 1'b0);
        end

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
